// File: rtl/modexp_engine_if.sv
// Request/response bundle for modexp_engine: operands and start in, status and result out.
interface modexp_engine_if #(
    parameter int W  = 128,
    parameter int EW = 128
);
    logic          start;
    logic [W-1:0]  base;
    logic [EW-1:0] exp;
    logic [W-1:0]  modulus;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          error;

    modport master (output start, base, exp, modulus, input busy, done, result, error);
    modport slave  (input start, base, exp, modulus, output busy, done, result, error);
endinterface

// File: rtl/modexp_engine.sv
// Modular exponentiation base^exp mod modulus with a bit-serial Blakley multiplier.
// Optional macro MODEXP_EARLY_EXIT_EN trades constant time for skipping idle MUL/SQR steps.
module modexp_engine #(
    parameter int W  = 128,
    parameter int EW = 128
) (
    input  logic            clk,
    input  logic            rst,
    modexp_engine_if.slave  bus
);
    localparam int CW = $clog2(W + 1);
    localparam int KW = $clog2(EW + 1);

    typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, DONE, DONE_ERR} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  base_q, n_q, acc, sq, r, a_sh, b_q, result_q;
    logic [EW-1:0] e_q;
    logic [CW-1:0] cnt;
    logic          error_q;
    logic [W-1:0]  a_sel, b_sel, prod, acc_nx;
    logic [W+1:0]  t0, t1, t2;
    logic          last_iter;
`ifdef MODEXP_EARLY_EXIT_EN
    logic [EW-1:0] e_rest;
    assign e_rest = e_q >> 1;
`else
    logic [KW-1:0] k;
`endif

    assign last_iter = (cnt == CW'(W));

    // One Blakley step: R = 2R + a*B, then at most two subtractions since 2R+B < 3N.
    always_comb begin
        t0   = {1'b0, r, 1'b0} + (a_sh[W-1] ? {2'b00, b_q} : '0);
        t1   = (t0 >= {2'b00, n_q}) ? t0 - {2'b00, n_q} : t0;
        t2   = (t1 >= {2'b00, n_q}) ? t1 - {2'b00, n_q} : t1;
        prod = t2[W-1:0];
    end

    always_comb begin
        a_sel = sq;
        b_sel = sq;
        case (state)
            REDUCE: begin
                a_sel = base_q;
                b_sel = W'(1);
            end
            MUL:     a_sel = acc;
            default: ;
        endcase
    end

    always_comb begin
        acc_nx = acc;
        if (last_iter) begin
            case (state)
                REDUCE:  acc_nx = (n_q == W'(1)) ? '0 : W'(1);
                MUL:     if (e_q[0]) acc_nx = prod;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (bus.start) state_nx = (bus.modulus == '0) ? DONE_ERR : REDUCE;
            REDUCE, MUL, SQR: begin
                if (last_iter) begin
`ifdef MODEXP_EARLY_EXIT_EN
                    case (state)
                        REDUCE:  state_nx = (e_q == '0) ? DONE : (e_q[0] ? MUL : SQR);
                        MUL:     state_nx = (e_rest == '0) ? DONE : SQR;
                        default: state_nx = e_rest[0] ? MUL : SQR;
                    endcase
`else
                    case (state)
                        REDUCE:  state_nx = MUL;
                        MUL:     state_nx = SQR;
                        default: state_nx = (k == KW'(EW - 1)) ? DONE : MUL;
                    endcase
`endif
                end
            end
            DONE, DONE_ERR: state_nx = IDLE;
            default:        state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            n_q      <= '0;
            e_q      <= '0;
            acc      <= '0;
            sq       <= '0;
            r        <= '0;
            a_sh     <= '0;
            b_q      <= '0;
            cnt      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
`ifndef MODEXP_EARLY_EXIT_EN
            k        <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q   <= bus.base;
                        e_q      <= bus.exp;
                        n_q      <= bus.modulus;
                        result_q <= '0;
                        error_q  <= (bus.modulus == '0);
                        cnt      <= '0;
`ifndef MODEXP_EARLY_EXIT_EN
                        k        <= '0;
`endif
                    end
                end
                REDUCE, MUL, SQR: begin
                    if (cnt == '0) begin
                        r    <= '0;
                        a_sh <= a_sel;
                        b_q  <= b_sel;
                        cnt  <= CW'(1);
                    end else begin
                        r    <= prod;
                        a_sh <= a_sh << 1;
                        cnt  <= last_iter ? '0 : cnt + CW'(1);
                        if (last_iter) begin
                            acc <= acc_nx;
                            if (state != MUL) sq <= prod;
                            if (state == SQR) begin
                                e_q <= e_q >> 1;
`ifndef MODEXP_EARLY_EXIT_EN
                                k   <= k + KW'(1);
`endif
                            end
                            if (state_nx == DONE) result_q <= acc_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == REDUCE) || (state == MUL) || (state == SQR);
    assign bus.done   = (state == DONE) || (state == DONE_ERR);
    assign bus.result = result_q;
    assign bus.error  = error_q;
endmodule
